zoom_controller: RTL and testbench
==================================

ZOOM_CONTROLLER -- requirements
Module: zoom_controller

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1048575, the maximum cycles to wait for DP_DONE before aborting.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 The block SHALL have these ports:
- CLK  in  1  clock
- RESET_N  in  1  synchronous active-low reset
- CMD_VALID  in  1  host command valid
- CMD_OPCODE  in  3  host command code
- CMD_READY  out  1  controller can accept a command
- DP_ENABLE  out  1  enable to the scaling datapath
- DP_ALGORITHM  out  2  algorithm select: 00 NN, 01 PR, 10 DC, 11 BA
- DP_IMAGE_STATE  out  2  target size for the datapath
- DP_DONE  in  1  datapath finished
- IMAGE_STATE  out  2  committed size: 0 = 160x120, 1 = 320x240, 2 = 80x60
- BUF_SEL  out  1  display buffer select
- BUSY  out  1  operation in progress
- DONE  out  1  one-cycle completion pulse
- ERROR  out  1  sticky error flag

Function
REQ-004 The opcodes SHALL be: 000 NOP; 001 NN zoom-in; 010 PR zoom-in; 011 DC zoom-out; 100 BA zoom-out; 101 RESET_IMG; 110 and 111 are illegal.
REQ-005 The state machine SHALL have the states S_IDLE, S_RUN, S_RELEASE, S_COMMIT and S_ERROR.
REQ-006 CMD_READY SHALL be 1 only in S_IDLE, and a command SHALL be accepted on the rising edge where CMD_VALID and CMD_READY are both 1.
REQ-007 Accepting any command SHALL clear ERROR on the same edge.
REQ-008 Zoom-in target SHALL be: state 0 -> 1, state 2 -> 0; zoom-in from state 1 is illegal.
REQ-009 Zoom-out target SHALL be: state 0 -> 2, state 1 -> 0; zoom-out from state 2 is illegal.
REQ-010 On a legal zoom command the controller SHALL:
- latch DP_ALGORITHM and DP_IMAGE_STATE (target) on the accepting edge
- go to S_RUN, where DP_ENABLE is 1 from the next cycle
- clear the timeout counter.
REQ-011 In S_RUN the timeout counter SHALL increment each cycle.
REQ-012 In S_RUN, DP_DONE = 1 SHALL cause a transition to S_RELEASE.
REQ-013 In S_RUN, with DP_DONE = 0 and counter == TIMEOUT_CYCLES-1, the controller SHALL transition to S_ERROR.
REQ-014 If DP_DONE and the timeout occur in the same cycle, DP_DONE SHALL win.
REQ-015 In S_RELEASE, DP_ENABLE SHALL be 0, and the controller SHALL stay there until DP_DONE = 0, then go to S_COMMIT.
REQ-016 S_COMMIT SHALL last one cycle and SHALL:
- load IMAGE_STATE with the target
- toggle BUF_SEL
- pulse DONE for that cycle
- return to S_IDLE.
REQ-017 NOP SHALL go to S_COMMIT without changing IMAGE_STATE or BUF_SEL.
REQ-018 RESET_IMG SHALL go to S_COMMIT and load IMAGE_STATE = 0 without toggling BUF_SEL; DP_ENABLE SHALL never be raised for NOP or RESET_IMG.
REQ-019 Illegal opcodes and illegal transitions SHALL go to S_ERROR with DP_ENABLE never raised.
REQ-020 S_ERROR SHALL last one cycle, set ERROR = 1, pulse DONE, leave IMAGE_STATE and BUF_SEL unchanged, and return to S_IDLE.
REQ-021 BUSY SHALL be 1 in every state except S_IDLE.
REQ-022 DP_ENABLE SHALL be 1 only in S_RUN.
REQ-023 DP_ALGORITHM and DP_IMAGE_STATE SHALL stay stable from acceptance until the next accepted command.
REQ-024 The timeout counter SHALL be 20 bits and SHALL saturate; it SHALL never wrap.

Reset
REQ-025 While RESET_N = 0 at a rising edge, the block SHALL enter S_IDLE and set:
- IMAGE_STATE = 0, DP_IMAGE_STATE = 0, DP_ALGORITHM = 00
- BUF_SEL = 0, ERROR = 0, DONE = 0
- DP_ENABLE = 0, BUSY = 0, counter = 0.
REQ-026 A reset during S_RUN SHALL drop DP_ENABLE at the reset edge and SHALL produce no DONE pulse.

Structure
REQ-027 The opcode, state, algorithm and image-state encodings SHALL live in the shared package coproc_pkg, which the datapath also uses.
REQ-028 The legal-transition/target lookup SHALL be the sub-module zoom_target_lut: combinational, inputs opcode and IMAGE_STATE, outputs target, algorithm and legal.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Reset, then opcode 001 with DP_DONE returned after 100 cycles -> DP_ENABLE high for 100 cycles, DP_ALGORITHM = 00, then one DONE pulse, IMAGE_STATE = 1, BUF_SEL = 1.
- From IMAGE_STATE 1, opcode 010 -> ERROR = 1, one DONE pulse, DP_ENABLE never 1, IMAGE_STATE remains 1.
- TIMEOUT_CYCLES = 16, opcode 100, DP_DONE held 0 -> DP_ENABLE drops after 16 cycles, ERROR = 1, IMAGE_STATE unchanged; the next opcode 000 clears ERROR.
- DP_DONE held high for 3 cycles after DP_ENABLE falls -> DONE fires only in the cycle after DP_DONE falls; CMD_READY stays 0 until then.
- RESET_N low during S_RUN -> the next edge gives DP_ENABLE = 0, IMAGE_STATE = 0, no DONE; opcode 101 from state 2 -> IMAGE_STATE = 0 and BUF_SEL unchanged.

Source files
------------

// File: rtl/coproc_pkg.sv
// Shared encodings for the zoom controller and the scaling datapath.
package coproc_pkg;

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_NN_IN     = 3'd1,
    OP_PR_IN     = 3'd2,
    OP_DC_OUT    = 3'd3,
    OP_BA_OUT    = 3'd4,
    OP_RESET_IMG = 3'd5,
    OP_ILL6      = 3'd6,
    OP_ILL7      = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ALG_NN = 2'd0,
    ALG_PR = 2'd1,
    ALG_DC = 2'd2,
    ALG_BA = 2'd3
  } algo_e;

  typedef enum logic [1:0] {
    IMG_160X120 = 2'd0,
    IMG_320X240 = 2'd1,
    IMG_80X60   = 2'd2,
    IMG_RSVD    = 2'd3
  } img_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_RELEASE = 3'd2,
    S_COMMIT  = 3'd3,
    S_ERROR   = 3'd4
  } state_e;

  localparam int unsigned TIMEOUT_W = 20;

  function automatic logic is_zoom(input opcode_e op);
    return (op == OP_NN_IN) || (op == OP_PR_IN) || (op == OP_DC_OUT) || (op == OP_BA_OUT);
  endfunction

endpackage

// File: rtl/zoom_target_lut.sv
// Combinational lookup: target size, algorithm and legality for a command.
module zoom_target_lut
  import coproc_pkg::*;
(
  input  opcode_e opcode,
  input  img_e    image_state,
  output img_e    target,
  output algo_e   algorithm,
  output logic    legal
);

  // Map opcode and current size to the next size; impossible steps are illegal
  always_comb begin
    target    = image_state;
    algorithm = ALG_NN;
    legal     = 1'b0;
    case (opcode)
      OP_NOP: legal = 1'b1;
      OP_NN_IN, OP_PR_IN: begin
        if (opcode == OP_PR_IN) algorithm = ALG_PR;
        case (image_state)
          IMG_160X120: begin target = IMG_320X240; legal = 1'b1; end
          IMG_80X60:   begin target = IMG_160X120; legal = 1'b1; end
          default: ;
        endcase
      end
      OP_DC_OUT, OP_BA_OUT: begin
        algorithm = (opcode == OP_BA_OUT) ? ALG_BA : ALG_DC;
        case (image_state)
          IMG_160X120: begin target = IMG_80X60;   legal = 1'b1; end
          IMG_320X240: begin target = IMG_160X120; legal = 1'b1; end
          default: ;
        endcase
      end
      OP_RESET_IMG: begin
        target = IMG_160X120;
        legal  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/zoom_controller.sv
// Zoom command sequencer: runs the scaling datapath and commits the new size.
module zoom_controller
  import coproc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CMD_VALID,
  input  logic [2:0] CMD_OPCODE,
  output logic       CMD_READY,
  output logic       DP_ENABLE,
  output logic [1:0] DP_ALGORITHM,
  output logic [1:0] DP_IMAGE_STATE,
  input  logic       DP_DONE,
  output logic [1:0] IMAGE_STATE,
  output logic       BUF_SEL,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR
);

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  algo_e                alg_q, alg_d;
  img_e                 dp_img_q, dp_img_d;
  img_e                 img_q, img_d;
  img_e                 pend_img_q, pend_img_d;
  logic                 pend_load_q, pend_load_d;
  logic                 pend_tog_q, pend_tog_d;
  logic                 buf_q, buf_d;
  logic                 err_q, err_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  img_e  lut_target;
  algo_e lut_alg;
  logic  lut_legal;
  opcode_e cmd_op;

  assign cmd_op = opcode_e'(CMD_OPCODE);

  zoom_target_lut u_lut (
    .opcode      (cmd_op),
    .image_state (img_q),
    .target      (lut_target),
    .algorithm   (lut_alg),
    .legal       (lut_legal)
  );

  // Next-state and register updates; commit effects are staged at acceptance
  // and applied in S_COMMIT so NOP, RESET_IMG and zooms share one exit path
  always_comb begin
    state_d     = state_q;
    alg_d       = alg_q;
    dp_img_d    = dp_img_q;
    img_d       = img_q;
    pend_img_d  = pend_img_q;
    pend_load_d = pend_load_q;
    pend_tog_d  = pend_tog_q;
    buf_d       = buf_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          err_d = 1'b0;
          cnt_d = '0;
          if (!lut_legal) begin
            state_d = S_ERROR;
          end else if (is_zoom(cmd_op)) begin
            alg_d       = lut_alg;
            dp_img_d    = lut_target;
            pend_img_d  = lut_target;
            pend_load_d = 1'b1;
            pend_tog_d  = 1'b1;
            state_d     = S_RUN;
          end else begin
            pend_img_d  = lut_target;
            pend_load_d = (cmd_op == OP_RESET_IMG);
            pend_tog_d  = 1'b0;
            state_d     = S_COMMIT;
          end
        end
      end
      S_RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (DP_DONE) state_d = S_RELEASE;
        else if (cnt_q == CNT_LAST) state_d = S_ERROR;
      end
      S_RELEASE: begin
        if (!DP_DONE) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        if (pend_load_q) img_d = pend_img_q;
        if (pend_tog_q) buf_d = ~buf_q;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      alg_q       <= ALG_NN;
      dp_img_q    <= IMG_160X120;
      img_q       <= IMG_160X120;
      pend_img_q  <= IMG_160X120;
      pend_load_q <= 1'b0;
      pend_tog_q  <= 1'b0;
      buf_q       <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      alg_q       <= alg_d;
      dp_img_q    <= dp_img_d;
      img_q       <= img_d;
      pend_img_q  <= pend_img_d;
      pend_load_q <= pend_load_d;
      pend_tog_q  <= pend_tog_d;
      buf_q       <= buf_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign CMD_READY      = (state_q == S_IDLE);
  assign BUSY           = (state_q != S_IDLE);
  assign DP_ENABLE      = (state_q == S_RUN);
  assign DONE           = (state_q == S_COMMIT) || (state_q == S_ERROR);
  assign DP_ALGORITHM   = alg_q;
  assign DP_IMAGE_STATE = dp_img_q;
  assign IMAGE_STATE    = img_q;
  assign BUF_SEL        = buf_q;
  assign ERROR          = err_q;

endmodule

// File: tb/tb_zoom_controller.sv
// Bench for zoom_controller: directed table, corner sequences, random vs model.
module tb_zoom_controller;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic       dp_done;
  logic       sel;

  logic       a_ready, a_en, a_buf, a_busy, a_done, a_err;
  logic [1:0] a_alg, a_dpimg, a_img;
  logic       b_ready, b_en, b_buf, b_busy, b_done, b_err;
  logic [1:0] b_alg, b_dpimg, b_img;

  logic       m_ready, m_en, m_buf, m_busy, m_done, m_err;
  logic [1:0] m_alg, m_dpimg, m_img;

  zoom_controller dut_a (
    .CLK(clk), .RESET_N(rst_n), .CMD_VALID(cmd_valid & ~sel), .CMD_OPCODE(cmd_op),
    .CMD_READY(a_ready), .DP_ENABLE(a_en), .DP_ALGORITHM(a_alg), .DP_IMAGE_STATE(a_dpimg),
    .DP_DONE(dp_done), .IMAGE_STATE(a_img), .BUF_SEL(a_buf), .BUSY(a_busy),
    .DONE(a_done), .ERROR(a_err)
  );

  zoom_controller #(.TIMEOUT_CYCLES(16)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .CMD_VALID(cmd_valid & sel), .CMD_OPCODE(cmd_op),
    .CMD_READY(b_ready), .DP_ENABLE(b_en), .DP_ALGORITHM(b_alg), .DP_IMAGE_STATE(b_dpimg),
    .DP_DONE(dp_done), .IMAGE_STATE(b_img), .BUF_SEL(b_buf), .BUSY(b_busy),
    .DONE(b_done), .ERROR(b_err)
  );

  assign m_ready = sel ? b_ready : a_ready;
  assign m_en    = sel ? b_en    : a_en;
  assign m_alg   = sel ? b_alg   : a_alg;
  assign m_dpimg = sel ? b_dpimg : a_dpimg;
  assign m_img   = sel ? b_img   : a_img;
  assign m_buf   = sel ? b_buf   : a_buf;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;
  assign m_err   = sel ? b_err   : a_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int r_en, r_done, r_rel, r_rdybad, r_tmo;

  typedef struct {
    int sel; int rst; int op; int da; int hold;
    int img; int bf; int err; int en; int alg; int dpimg;
  } vec_t;

  vec_t tbl [14];
  int tgt_in [4];
  int tgt_out [4];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    dp_done = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_ready", int'(m_ready), 1);
    chk("rst_en",    int'(m_en),    0);
    chk("rst_busy",  int'(m_busy),  0);
    chk("rst_done",  int'(m_done),  0);
    chk("rst_err",   int'(m_err),   0);
    chk("rst_img",   int'(m_img),   0);
    chk("rst_buf",   int'(m_buf),   0);
    chk("rst_alg",   int'(m_alg),   0);
    chk("rst_dpimg", int'(m_dpimg), 0);
  endtask

  // Issue one command and follow it back to idle; done_at is the enable cycle
  // in which DP_DONE rises, hold is extra cycles DP_DONE stays up afterwards
  task automatic run_cmd(input int op, input int done_at, input int hold);
    int hcnt;
    r_en = 0; r_done = 0; r_rel = 0; r_rdybad = 0; r_tmo = 0; hcnt = 0;
    dp_done = 1'b0;
    cmd_op = 3'(op);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (m_ready == m_busy) r_rdybad++;
      if (m_done) r_done++;
      if (m_en) begin
        r_en++;
        if (r_en == done_at) dp_done = 1'b1;
      end else if (m_busy && !m_done) begin
        r_rel++;
        hcnt++;
        if (hcnt > hold) dp_done = 1'b0;
      end
      if (!m_busy) break;
      tick();
    end
    if (m_busy) r_tmo = 1;
    dp_done = 1'b0;
  endtask

  task automatic check_txn(input int e_img, input int e_buf, input int e_err, input int e_en,
                           input int e_rel, input int e_alg, input int e_dpimg);
    chk("no_hang",     r_tmo,          0);
    chk("en_cycles",   r_en,           e_en);
    chk("done_pulses", r_done,         1);
    chk("rel_cycles",  r_rel,          e_rel);
    chk("ready_busy",  r_rdybad,       0);
    chk("image_state", int'(m_img),    e_img);
    chk("buf_sel",     int'(m_buf),    e_buf);
    chk("error",       int'(m_err),    e_err);
    chk("dp_alg",      int'(m_alg),    e_alg);
    chk("dp_img",      int'(m_dpimg),  e_dpimg);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    int e_rel;
    int mi, mb, me, ma, md;
    int op, da, hd, tgt, zoom, legal, e_en;

    checks = 0; errors = 0;
    sel = 1'b0; rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; dp_done = 1'b0;

    //           sel rst op  da    hold img buf err en  alg dpimg
    tbl[0]  = '{0, 1, 1, 100,  0,   1,  1,  0, 100, 0, 1};
    tbl[1]  = '{0, 0, 2, 5,    0,   1,  1,  1, 0,   0, 1};
    tbl[2]  = '{0, 0, 0, 5,    0,   1,  1,  0, 0,   0, 1};
    tbl[3]  = '{0, 0, 3, 5,    3,   0,  0,  0, 5,   2, 0};
    tbl[4]  = '{0, 0, 4, 1,    0,   2,  1,  0, 1,   3, 2};
    tbl[5]  = '{0, 0, 4, 5,    0,   2,  1,  1, 0,   3, 2};
    tbl[6]  = '{0, 0, 6, 5,    0,   2,  1,  1, 0,   3, 2};
    tbl[7]  = '{0, 0, 5, 5,    0,   0,  1,  0, 0,   3, 2};
    tbl[8]  = '{0, 0, 2, 2,    1,   1,  0,  0, 2,   1, 1};
    tbl[9]  = '{0, 0, 7, 5,    0,   1,  0,  1, 0,   1, 1};
    tbl[10] = '{1, 1, 4, 1000, 0,   0,  0,  1, 16,  3, 2};
    tbl[11] = '{1, 0, 0, 5,    0,   0,  0,  0, 0,   3, 2};
    tbl[12] = '{1, 0, 4, 16,   0,   2,  1,  0, 16,  3, 2};
    tbl[13] = '{1, 0, 1, 17,   0,   2,  1,  1, 16,  0, 0};

    for (int i = 0; i < 14; i++) begin
      sel = tbl[i].sel[0];
      if (tbl[i].rst != 0) do_reset();
      run_cmd(tbl[i].op, tbl[i].da, tbl[i].hold);
      e_rel = (tbl[i].en > 0 && tbl[i].err == 0) ? tbl[i].hold + 1 : 0;
      check_txn(tbl[i].img, tbl[i].bf, tbl[i].err, tbl[i].en, e_rel, tbl[i].alg, tbl[i].dpimg);
    end

    // Reset while the datapath is running
    sel = 1'b0;
    do_reset();
    run_cmd(4, 3, 0);
    chk("pre_rst_img", int'(m_img), 2);
    cmd_op = 3'd1;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    dn = 0;
    for (int k = 0; k < 5; k++) begin
      if (m_en) dn++;
      tick();
    end
    chk("run_en_before_rst", dn, 5);
    rst_n = 1'b0;
    tick();
    chk("midrun_rst_en",   int'(m_en),   0);
    chk("midrun_rst_img",  int'(m_img),  0);
    chk("midrun_rst_done", int'(m_done), 0);
    chk("midrun_rst_busy", int'(m_busy), 0);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (m_done) dn++;
    end
    chk("midrun_rst_no_done", dn, 0);

    // Random commands on the short-timeout instance against a transaction model
    tgt_in[0] = 1;  tgt_in[1] = -1; tgt_in[2] = 0;  tgt_in[3] = -1;
    tgt_out[0] = 2; tgt_out[1] = 0; tgt_out[2] = -1; tgt_out[3] = -1;
    sel = 1'b1;
    do_reset();
    mi = 0; mb = 0; me = 0; ma = 0; md = 0;
    for (int t = 0; t < 60; t++) begin
      op = int'($urandom_range(0, 7));
      da = int'($urandom_range(1, 20));
      hd = int'($urandom_range(0, 3));
      zoom = (op >= 1 && op <= 4) ? 1 : 0;
      tgt = (op <= 2) ? tgt_in[mi] : tgt_out[mi];
      legal = zoom ? (tgt >= 0 ? 1 : 0) : (op <= 5 ? 1 : 0);
      e_en = 0;
      e_rel = 0;
      if (legal == 0) begin
        me = 1;
      end else if (zoom != 0) begin
        ma = op - 1;
        md = tgt;
        e_en = (da <= 16) ? da : 16;
        if (da > 16) begin
          me = 1;
        end else begin
          mi = tgt;
          mb = 1 - mb;
          me = 0;
          e_rel = hd + 1;
        end
      end else begin
        me = 0;
        if (op == 5) mi = 0;
      end
      run_cmd(op, da, hd);
      check_txn(mi, mb, me, e_en, e_rel, ma, md);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
